// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst master: default widths and FSM encoding.
package ram_pkg;

  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWr    = 3'd1,
    StRdReq = 3'd2,
    StRdCap = 3'd3,
    StRdOut = 3'd4
  } state_e;

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, write-data, read-data and RAM-port signals of the burst master.
// The master modport is the controller view; slave is the sequencer/RAM view.
interface ram_burst_master_if
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;

  logic              busy;
  logic              done;

  logic              ram_cen;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wdata_valid, wdata, rdata_ready, ram_dout,
    output cmd_ready, wdata_ready, rdata_valid, rdata, busy, done,
    output ram_cen, ram_wen, ram_addr, ram_din
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wdata_valid, wdata, rdata_ready, ram_dout,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, busy, done,
    input  ram_cen, ram_wen, ram_addr, ram_din
  );

endinterface

// File: rtl/ram_burst_master.sv
// Burst controller for a single-port synchronous RAM with 1-cycle registered read data.
// Writes stream one beat per cycle; reads issue, capture, then present each beat.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input logic                clk,
  input logic                rst_n,
  ram_burst_master_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;

  // Burst sequencing: address/beat counters, read capture and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            cur_addr_q  <= bus.cmd_addr;
            remaining_q <= bus.cmd_len;
            state_q     <= bus.cmd_write ? StWr : StRdReq;
          end
        end
        StWr: begin
          if (bus.wdata_valid) begin
            cur_addr_q <= cur_addr_q + 1'b1;  // wraps at the top of the RAM
            if (remaining_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              remaining_q <= remaining_q - 1'b1;
            end
          end
        end
        StRdReq: state_q <= StRdCap;
        StRdCap: begin
          // RAM dout still holds the read issued last cycle; it zeroes only after this edge.
          rdata_q <= bus.ram_dout;
          state_q <= StRdOut;
        end
        StRdOut: begin
          if (bus.rdata_ready) begin
            cur_addr_q <= cur_addr_q + 1'b1;
            if (remaining_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              remaining_q <= remaining_q - 1'b1;
              state_q     <= StRdReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and RAM-port outputs decoded from state; RAM port idles in IDLE.
  always_comb begin
    bus.cmd_ready   = (state_q == StIdle);
    bus.busy        = (state_q != StIdle);
    bus.done        = done_q;
    bus.wdata_ready = (state_q == StWr);
    bus.rdata_valid = (state_q == StRdOut);
    bus.rdata       = rdata_q;
    bus.ram_cen     = ((state_q == StWr) && bus.wdata_valid) || (state_q == StRdReq);
    bus.ram_wen     = (state_q == StWr);
    bus.ram_addr    = (state_q == StIdle) ? '0 : cur_addr_q;
    bus.ram_din     = (state_q == StWr) ? bus.wdata : '0;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM behind it.
module tb_ram_burst_master;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // RAM model: registered read, dout zero on write or when disabled.
  logic [DW-1:0] mem [32];
  always_ff @(posedge clk) begin
    if (bus.ram_cen) begin
      if (bus.ram_wen) begin
        mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout      <= '0;
      end else begin
        bus.ram_dout <= mem[bus.ram_addr];
      end
    end else begin
      bus.ram_dout <= '0;
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit              wr;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   len;
    logic [3:0][31:0] d;
    int              stall_beat;
    int              stall_cyc;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      n_fail++;
    end
  endtask

  // Waits for rdata_valid, counting cycles and RAM enables along the way.
  task automatic wait_valid(input logic [AW-1:0] exp_addr, output int n, output int cen);
    n   = 0;
    cen = 0;
    while (!bus.rdata_valid && n < 20) begin
      if (bus.ram_cen) begin
        cen++;
        check("rd_req_addr", 32'(bus.ram_addr), 32'(exp_addr));
        check("rd_req_wen", 32'(bus.ram_wen), 32'd0);
      end
      step();
      n++;
    end
  endtask

  task automatic run_write(input vec_t v);
    logic [AW-1:0] a;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    #1;
    check("wr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    #1;
    check("wr_done_clr", 32'(bus.done), 32'd0);
    check("wr_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.addr + AW'(i);
      if (i == v.stall_beat) begin
        for (int s = 0; s < v.stall_cyc; s++) begin
          bus.wdata_valid = 1'b0;
          #1;
          check("wr_stall_cen", 32'(bus.ram_cen), 32'd0);
          check("wr_stall_ready", 32'(bus.wdata_ready), 32'd1);
          step();
        end
      end
      bus.wdata_valid = 1'b1;
      bus.wdata       = v.d[i];
      #1;
      check("wr_ready", 32'(bus.wdata_ready), 32'd1);
      check("wr_cen", 32'(bus.ram_cen), 32'd1);
      check("wr_wen", 32'(bus.ram_wen), 32'd1);
      check("wr_addr", 32'(bus.ram_addr), 32'(a));
      check("wr_din", bus.ram_din, v.d[i]);
      step();
    end
    bus.wdata_valid = 1'b0;
    #1;
    check("wr_len_exit", 32'(bus.wdata_ready), 32'd0);
    check("wr_done", 32'(bus.done), 32'd1);
    check("wr_busy_fall", 32'(bus.busy), 32'd0);
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.addr + AW'(i);
      check("wr_mem", mem[a], v.d[i]);
    end
  endtask

  task automatic run_read(input vec_t v);
    int n;
    int cen;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = v.addr;
    bus.cmd_len     = v.len;
    bus.rdata_ready = 1'b1;
    #1;
    check("rd_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    #1;
    check("rd_done_clr", 32'(bus.done), 32'd0);
    for (int i = 0; i <= int'(v.len); i++) begin
      wait_valid(v.addr + AW'(i), n, cen);
      check("rd_latency", 32'(n), 32'd2);
      check("rd_cen_count", 32'(cen), 32'd1);
      check("rd_data", bus.rdata, v.d[i]);
      check("rd_out_cen", 32'(bus.ram_cen), 32'd0);
      if (i == v.stall_beat) begin
        bus.rdata_ready = 1'b0;
        for (int s = 0; s < v.stall_cyc; s++) begin
          step();
          check("bp_valid", 32'(bus.rdata_valid), 32'd1);
          check("bp_data", bus.rdata, v.d[i]);
          check("bp_cen", 32'(bus.ram_cen), 32'd0);
        end
        bus.rdata_ready = 1'b1;
      end
      step();
      if (i < int'(v.len)) check("rd_done_mid", 32'(bus.done), 32'd0);
    end
    check("rd_done", 32'(bus.done), 32'd1);
    check("rd_busy_fall", 32'(bus.busy), 32'd0);
    check("rd_valid_fall", 32'(bus.rdata_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cen;
    vec_t one;

    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b1;

    vecs[0] = '{1'b1, 5'd4,  5'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0};
    vecs[1] = '{1'b0, 5'd4,  5'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0};
    vecs[2] = '{1'b0, 5'd4,  5'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0},  1, 5};
    vecs[3] = '{1'b1, 5'd30, 5'd3, {32'h4,  32'h3,  32'h2,  32'h1},  -1, 0};
    vecs[4] = '{1'b0, 5'd30, 5'd3, {32'h4,  32'h3,  32'h2,  32'h1},  -1, 0};
    vecs[5] = '{1'b1, 5'd12, 5'd1, {32'h0,  32'h0,  32'h22, 32'h11},  1, 2};
    vecs[6] = '{1'b0, 5'd12, 5'd1, {32'h0,  32'h0,  32'h22, 32'h11}, -1, 0};
    vecs[7] = '{1'b0, 5'd31, 5'd0, {32'h0,  32'h0,  32'h0,  32'h2},  -1, 0};

    // Outputs while reset is held.
    #2;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_cen", 32'(bus.ram_cen), 32'd0);
    check("rst_wen", 32'(bus.ram_wen), 32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_din", bus.ram_din, 32'd0);
    check("rst_wready", 32'(bus.wdata_ready), 32'd0);
    check("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    #10;
    rst_n = 1'b1;

    // Idle with no commands.
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("idle_cen", 32'(bus.ram_cen), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
    end

    // Table: each burst starts in the cycle where the previous done is high.
    for (int k = 0; k < 8; k++) begin
      if (vecs[k].wr) run_write(vecs[k]);
      else run_read(vecs[k]);
    end
    step();
    check("post_done_clr", 32'(bus.done), 32'd0);

    // Abort a 4-beat read during its third beat.
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 5'd4;
    bus.cmd_len     = 5'd3;
    bus.rdata_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_valid(5'd4 + AW'(i), n, cen);
      check("ab_data", bus.rdata, 32'hA0 + 32'(i));
      step();
    end
    wait_valid(5'd6, n, cen);
    check("ab_beat3_valid", 32'(bus.rdata_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ab_cen", 32'(bus.ram_cen), 32'd0);
    check("ab_valid", 32'(bus.rdata_valid), 32'd0);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_done", 32'(bus.done), 32'd0);
    step();
    check("ab_done_hold", 32'(bus.done), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("ab_post_busy", 32'(bus.busy), 32'd0);
    check("ab_post_done", 32'(bus.done), 32'd0);
    one = '{1'b0, 5'd0, 5'd0, {32'h0, 32'h0, 32'h0, 32'h3}, -1, 0};
    run_read(one);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
